// File: rtl/conv1d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_pkg
// Desc     : Shared FSM states, config addresses and conv1d command codes.
// Revision : 1.0 - initial release
// ============================================================================
package conv1d_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD_IN  = 4'd1,
        ST_LOAD_FLT = 4'd2,
        ST_PARAMS   = 4'd3,
        ST_START    = 4'd4,
        ST_POLL     = 4'd5,
        ST_READ     = 4'd6,
        ST_RESP     = 4'd7
    } seq_state_e;

    localparam logic [3:0] c_cfg_input_offset = 4'd0;
    localparam logic [3:0] c_cfg_input_depth  = 4'd1;
    localparam logic [3:0] c_cfg_start_x      = 4'd2;
    localparam logic [3:0] c_cfg_bias         = 4'd3;
    localparam logic [3:0] c_cfg_multiplier   = 4'd4;
    localparam logic [3:0] c_cfg_shift        = 4'd5;
    localparam logic [3:0] c_cfg_act_min      = 4'd6;
    localparam logic [3:0] c_cfg_act_max      = 4'd7;
    localparam logic [3:0] c_cfg_out_offset   = 4'd8;
    localparam logic [3:0] c_cfg_in_base      = 4'd9;
    localparam logic [3:0] c_cfg_in_len       = 4'd10;
    localparam logic [3:0] c_cfg_flt_len      = 4'd11;

    localparam logic [6:0] c_cmd_load_in      = 7'd1;
    localparam logic [6:0] c_cmd_load_flt     = 7'd2;
    localparam logic [6:0] c_cmd_input_offset = 7'd3;
    localparam logic [6:0] c_cmd_input_depth  = 7'd5;
    localparam logic [6:0] c_cmd_start        = 7'd6;
    localparam logic [6:0] c_cmd_read         = 7'd7;
    localparam logic [6:0] c_cmd_start_x      = 7'd8;
    localparam logic [6:0] c_cmd_poll         = 7'd9;
    localparam logic [6:0] c_cmd_bias         = 7'd12;
    localparam logic [6:0] c_cmd_multiplier   = 7'd13;
    localparam logic [6:0] c_cmd_shift        = 7'd14;
    localparam logic [6:0] c_cmd_act_min      = 7'd15;
    localparam logic [6:0] c_cmd_act_max      = 7'd16;
    localparam logic [6:0] c_cmd_out_offset   = 7'd17;

    localparam logic [3:0] c_num_params = 4'd9;

    // Command issued in each PARAMS slot, in issue order.
    function automatic logic [6:0] param_cmd(input logic [3:0] idx);
        logic [6:0] cmd;
        cmd = 7'd0;
        case (idx)
            4'd0:    cmd = c_cmd_input_offset;
            4'd1:    cmd = c_cmd_input_depth;
            4'd2:    cmd = c_cmd_start_x;
            4'd3:    cmd = c_cmd_bias;
            4'd4:    cmd = c_cmd_multiplier;
            4'd5:    cmd = c_cmd_shift;
            4'd6:    cmd = c_cmd_act_min;
            4'd7:    cmd = c_cmd_act_max;
            4'd8:    cmd = c_cmd_out_offset;
            default: cmd = 7'd0;
        endcase
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ring_addr_gen
// Desc     : Load index counter with ring-wrapped input address generation.
// Revision : 1.0 - initial release
// ============================================================================
module ring_addr_gen #(
    parameter int IDX_W  = 32,
    parameter int BASE_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic              i_flt,
    input  logic [BASE_W-1:0] i_base,
    input  logic [IDX_W-1:0]  i_depth,
    output logic [IDX_W-1:0]  o_idx,
    output logic [IDX_W-1:0]  o_addr
);

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_ring;
    logic [IDX_W-1:0] w_sum;
    logic             w_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_step) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Ring is 8 entries per unit of depth; a zero ring disables wrapping.
    assign w_ring = i_depth << 3;
    assign w_sum  = IDX_W'(i_base) + r_idx;
    assign w_wrap = (w_ring != '0) && (w_sum >= w_ring);

    assign o_idx  = r_idx;
    assign o_addr = i_flt ? r_idx : (w_wrap ? (w_sum - w_ring) : w_sum);

endmodule
`default_nettype wire

// File: rtl/conv1d_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_host_sequencer
// Desc     : Drives a conv1d target: buffer loads, params, start, poll, read.
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_host_sequencer
    import conv1d_pkg::*;
#(
    parameter int BYTE_SIZE    = 8,
    parameter int INT32_SIZE   = 32,
    parameter int BUF_ADDR_W   = 10,
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [INT32_SIZE-1:0] cfg_wdata,
    input  logic                  go,
    output logic                  busy,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [BYTE_SIZE-1:0]  byte_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [INT32_SIZE-1:0] res_data,
    output logic                  res_timeout,
    output logic                  cfu_en,
    output logic [6:0]            cfu_cmd,
    output logic [INT32_SIZE-1:0] cfu_inp0,
    output logic [INT32_SIZE-1:0] cfu_inp1,
    input  logic [INT32_SIZE-1:0] cfu_ret
);

    localparam int c_poll_w = $clog2(POLL_TIMEOUT + 1);
    localparam logic [c_poll_w-1:0]   c_poll_last = c_poll_w'(POLL_TIMEOUT - 1);
    localparam logic [INT32_SIZE-1:0] c_one       = INT32_SIZE'(1);

    seq_state_e r_state;
    seq_state_e w_state_nxt;

    logic [INT32_SIZE-1:0] r_input_offset;
    logic [INT32_SIZE-1:0] r_input_depth;
    logic [INT32_SIZE-1:0] r_start_x;
    logic [INT32_SIZE-1:0] r_bias;
    logic [INT32_SIZE-1:0] r_multiplier;
    logic [INT32_SIZE-1:0] r_shift;
    logic [INT32_SIZE-1:0] r_act_min;
    logic [INT32_SIZE-1:0] r_act_max;
    logic [INT32_SIZE-1:0] r_out_offset;
    logic [BUF_ADDR_W-1:0] r_in_base;
    logic [INT32_SIZE-1:0] r_in_len;
    logic [INT32_SIZE-1:0] r_flt_len;

    logic [3:0]            r_pcnt;
    logic [c_poll_w-1:0]   r_poll_cnt;
    logic                  r_poll_prev;
    logic                  r_read_wait;
    logic [INT32_SIZE-1:0] r_res_data;
    logic                  r_res_timeout;

    logic                  w_hs;
    logic                  w_load_last;
    logic                  w_done;
    logic                  w_timeout;
    logic [INT32_SIZE-1:0] w_idx;
    logic [INT32_SIZE-1:0] w_addr;
    logic [INT32_SIZE-1:0] w_param_val;
    logic [INT32_SIZE-1:0] w_byte_ext;

    ring_addr_gen #(
        .IDX_W  (INT32_SIZE),
        .BASE_W (BUF_ADDR_W)
    ) u_ring_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear ((r_state == ST_IDLE) || w_load_last),
        .i_step  (w_hs),
        .i_flt   (r_state == ST_LOAD_FLT),
        .i_base  (r_in_base),
        .i_depth (r_input_depth),
        .o_idx   (w_idx),
        .o_addr  (w_addr)
    );

    assign w_byte_ext  = {{(INT32_SIZE-BYTE_SIZE){1'b0}}, byte_data};
    // A done bit is only meaningful when the previous cycle carried a poll.
    assign w_done      = r_poll_prev && cfu_ret[0];
    assign w_timeout   = (r_state == ST_POLL) && !w_done && (r_poll_cnt == c_poll_last);
    assign busy        = (r_state != ST_IDLE);
    assign res_valid   = (r_state == ST_RESP);
    assign res_data    = r_res_data;
    assign res_timeout = r_res_timeout;

    always_comb begin
        w_param_val = '0;
        case (r_pcnt)
            4'd0:    w_param_val = r_input_offset;
            4'd1:    w_param_val = r_input_depth;
            4'd2:    w_param_val = r_start_x;
            4'd3:    w_param_val = r_bias;
            4'd4:    w_param_val = r_multiplier;
            4'd5:    w_param_val = r_shift;
            4'd6:    w_param_val = r_act_min;
            4'd7:    w_param_val = r_act_max;
            4'd8:    w_param_val = r_out_offset;
            default: w_param_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfu_en      = 1'b0;
        cfu_cmd     = 7'd0;
        cfu_inp0    = '0;
        cfu_inp1    = '0;
        byte_ready  = 1'b0;
        w_hs        = 1'b0;
        w_load_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    if (r_in_len != '0) begin
                        w_state_nxt = ST_LOAD_IN;
                    end else if (r_flt_len != '0) begin
                        w_state_nxt = ST_LOAD_FLT;
                    end else begin
                        w_state_nxt = ST_PARAMS;
                    end
                end
            end
            ST_LOAD_IN: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_hs     = 1'b1;
                    cfu_en   = 1'b1;
                    cfu_cmd  = c_cmd_load_in;
                    cfu_inp0 = w_addr;
                    cfu_inp1 = w_byte_ext;
                    if (w_idx == r_in_len - c_one) begin
                        w_load_last = 1'b1;
                        w_state_nxt = (r_flt_len != '0) ? ST_LOAD_FLT : ST_PARAMS;
                    end
                end
            end
            ST_LOAD_FLT: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_hs     = 1'b1;
                    cfu_en   = 1'b1;
                    cfu_cmd  = c_cmd_load_flt;
                    cfu_inp0 = w_addr;
                    cfu_inp1 = w_byte_ext;
                    if (w_idx == r_flt_len - c_one) begin
                        w_load_last = 1'b1;
                        w_state_nxt = ST_PARAMS;
                    end
                end
            end
            ST_PARAMS: begin
                cfu_en   = 1'b1;
                cfu_cmd  = param_cmd(r_pcnt);
                cfu_inp1 = w_param_val;
                if (r_pcnt == c_num_params - 4'd1) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                cfu_en      = 1'b1;
                cfu_cmd     = c_cmd_start;
                w_state_nxt = ST_POLL;
            end
            ST_POLL: begin
                cfu_en  = 1'b1;
                cfu_cmd = c_cmd_poll;
                if (w_done) begin
                    w_state_nxt = ST_READ;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_READ: begin
                // First cycle issues the read; second cycle captures its return.
                if (!r_read_wait) begin
                    cfu_en  = 1'b1;
                    cfu_cmd = c_cmd_read;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_input_offset <= '0;
            r_input_depth  <= '0;
            r_start_x      <= '0;
            r_bias         <= '0;
            r_multiplier   <= '0;
            r_shift        <= '0;
            r_act_min      <= '0;
            r_act_max      <= '0;
            r_out_offset   <= '0;
            r_in_base      <= '0;
            r_in_len       <= '0;
            r_flt_len      <= '0;
        end else if (cfg_we && (r_state == ST_IDLE)) begin
            case (cfg_addr)
                c_cfg_input_offset: r_input_offset <= cfg_wdata;
                c_cfg_input_depth:  r_input_depth  <= cfg_wdata;
                c_cfg_start_x:      r_start_x      <= cfg_wdata;
                c_cfg_bias:         r_bias         <= cfg_wdata;
                c_cfg_multiplier:   r_multiplier   <= cfg_wdata;
                c_cfg_shift:        r_shift        <= cfg_wdata;
                c_cfg_act_min:      r_act_min      <= cfg_wdata;
                c_cfg_act_max:      r_act_max      <= cfg_wdata;
                c_cfg_out_offset:   r_out_offset   <= cfg_wdata;
                c_cfg_in_base:      r_in_base      <= cfg_wdata[BUF_ADDR_W-1:0];
                c_cfg_in_len:       r_in_len       <= cfg_wdata;
                c_cfg_flt_len:      r_flt_len      <= cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt        <= '0;
            r_poll_cnt    <= '0;
            r_poll_prev   <= 1'b0;
            r_read_wait   <= 1'b0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_pcnt      <= (r_state == ST_PARAMS) ? r_pcnt + 4'd1 : 4'd0;
            r_poll_cnt  <= (r_state == ST_POLL) ? r_poll_cnt + c_poll_w'(1) : '0;
            r_poll_prev <= (r_state == ST_POLL);
            r_read_wait <= (r_state == ST_READ) && !r_read_wait;
            if (w_timeout) begin
                r_res_data    <= '0;
                r_res_timeout <= 1'b1;
            end else if ((r_state == ST_READ) && r_read_wait) begin
                r_res_data    <= cfu_ret;
                r_res_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1d_host_sequencer
// Desc     : Scoreboard bench with a model conv1d responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv1d_host_sequencer;

    typedef struct packed {
        logic [6:0]  cmd;
        logic [31:0] a0;
        logic [31:0] a1;
    } cfu_op_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        go = 1'b0;
    logic        busy;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [7:0]  byte_data = 8'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        cfu_en;
    logic [6:0]  cfu_cmd;
    logic [31:0] cfu_inp0;
    logic [31:0] cfu_inp1;
    logic [31:0] cfu_ret = 32'd0;

    int          errors = 0;
    int          checks = 0;
    cfu_op_t     sb[$];
    cfu_op_t     mon_exp;
    logic [7:0]  byte_q[$];
    logic [31:0] m_cfg [12];
    logic [6:0]  exp_seq [10];
    logic [6:0]  last_cmd = 7'd0;
    int          polls = 0;
    int          done_at = 0;
    int          n_cmd2 = 0;
    logic [31:0] read_val = 32'd0;

    conv1d_host_sequencer #(
        .BYTE_SIZE    (8),
        .INT32_SIZE   (32),
        .BUF_ADDR_W   (10),
        .POLL_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .go          (go),
        .busy        (busy),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .cfu_en      (cfu_en),
        .cfu_cmd     (cfu_cmd),
        .cfu_inp0    (cfu_inp0),
        .cfu_inp1    (cfu_inp1),
        .cfu_ret     (cfu_ret)
    );

    always #5 clk = ~clk;

    // Command monitor: every issued command must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_cmd = 7'd0;
        end else if (cfu_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got cmd=%0d inp0=%h inp1=%h, required no command", cfu_cmd, cfu_inp0, cfu_inp1);
            end else begin
                mon_exp = sb.pop_front();
                if ({cfu_cmd, cfu_inp0, cfu_inp1} !== mon_exp) begin
                    errors++;
                    $display("FAIL cmd_seq: got cmd=%0d inp0=%h inp1=%h, required cmd=%0d inp0=%h inp1=%h",
                             cfu_cmd, cfu_inp0, cfu_inp1, mon_exp.cmd, mon_exp.a0, mon_exp.a1);
                end
            end
            if (cfu_cmd == 7'd2) n_cmd2++;
            last_cmd = cfu_cmd;
        end else begin
            checks++;
            if (cfu_en !== 1'b0 || cfu_cmd !== 7'd0 || cfu_inp0 !== 32'd0 || cfu_inp1 !== 32'd0) begin
                errors++;
                $display("FAIL idle_zero: got en=%b cmd=%0d inp0=%h inp1=%h, required all 0", cfu_en, cfu_cmd, cfu_inp0, cfu_inp1);
            end
            last_cmd = 7'd0;
        end
    end

    // Target model: returns depend on the command issued in the previous cycle.
    always @(posedge clk) begin
        #1;
        if (last_cmd == 7'd9) begin
            polls++;
            cfu_ret = (done_at != 0 && polls >= done_at) ? 32'h0000_0001 : 32'hFFFF_FFFE;
        end else if (last_cmd == 7'd7) begin
            cfu_ret = read_val;
        end else begin
            if (last_cmd == 7'd6) polls = 0;
            cfu_ret = 32'h0000_0001;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input bit applies);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 32'd0;
        if (applies && a < 4'd12) m_cfg[a] = d;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic push_op(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1);
        sb.push_back('{cmd: c, a0: a0, a1: a1});
    endtask

    task automatic push_params_and_start();
        for (int k = 0; k < 9; k++) push_op(exp_seq[k], 32'd0, m_cfg[k]);
        push_op(7'd6, 32'd0, 32'd0);
    endtask

    task automatic push_polls_read(input int n, input bit with_read);
        for (int k = 0; k < n; k++) push_op(7'd9, 32'd0, 32'd0);
        if (with_read) push_op(7'd7, 32'd0, 32'd0);
    endtask

    task automatic drive_bytes(input bit gap);
        int  k = 0;
        int  guard = 0;
        bit  ph = 1'b1;
        bit  hs;
        while (k < byte_q.size() && guard < 200) begin
            byte_valid = gap ? ph : 1'b1;
            byte_data  = byte_q[k];
            @(negedge clk);
            hs = byte_valid && byte_ready;
            if (!byte_valid) begin
                checks++;
                if (cfu_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_no_en: got cfu_en=%b, required 0", cfu_en);
                end
            end
            @(posedge clk); #1;
            if (hs) k++;
            ph = !ph;
            guard++;
        end
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        checks++;
        if (k != byte_q.size()) begin
            errors++;
            $display("FAIL bytes_accepted: got %0d, required %0d", k, byte_q.size());
        end
    endtask

    task automatic wait_res(output bit ok);
        int n = 0;
        @(negedge clk);
        while (res_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = (res_valid === 1'b1);
    endtask

    task automatic finish_resp();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: got busy=%b res_valid=%b, required 0 0", busy, res_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d pending commands, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_result(input bit ok, input logic [31:0] d, input logic t);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL res_wait: got no res_valid, required res_valid within budget");
        end
        checks++;
        if (res_data !== d || res_timeout !== t) begin
            errors++;
            $display("FAIL res_value: got data=%h timeout=%b, required data=%h timeout=%b", res_data, res_timeout, d, t);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || res_valid !== 1'b0 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got busy=%b byte_ready=%b res_valid=%b res_timeout=%b, required 0", busy, byte_ready, res_valid, res_timeout);
        end
        checks++;
        if (res_data !== 32'd0 || cfu_en !== 1'b0 || cfu_cmd !== 7'd0 || cfu_inp0 !== 32'd0 || cfu_inp1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got res_data=%h en=%b cmd=%0d, required 0", res_data, cfu_en, cfu_cmd);
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_in_wrap();
        bit ok;
        logic [31:0] exp_addr [8];
        exp_addr = '{32'd12, 32'd13, 32'd14, 32'd15, 32'd0, 32'd1, 32'd2, 32'd3};
        cfg_write(4'd0, 32'h0000_0080, 1'b1);
        cfg_write(4'd1, 32'd2, 1'b1);
        cfg_write(4'd2, 32'd3, 1'b1);
        cfg_write(4'd3, 32'h0000_0100, 1'b1);
        cfg_write(4'd4, 32'h4000_0000, 1'b1);
        cfg_write(4'd5, 32'hFFFF_FFF9, 1'b1);
        cfg_write(4'd6, 32'hFFFF_FF80, 1'b1);
        cfg_write(4'd7, 32'h0000_007F, 1'b1);
        cfg_write(4'd8, 32'd5, 1'b1);
        cfg_write(4'd9, 32'd12, 1'b1);
        cfg_write(4'd10, 32'd8, 1'b1);
        cfg_write(4'd11, 32'd0, 1'b1);
        byte_q.delete();
        for (int k = 0; k < 8; k++) begin
            byte_q.push_back(8'(k + 1));
            push_op(7'd1, exp_addr[k], 32'(k + 1));
        end
        push_params_and_start();
        push_polls_read(6, 1'b1);
        done_at = 5;
        read_val = 32'hFFFF_FF85;
        pulse_go();
        drive_bytes(1'b0);
        wait_res(ok);
        check_result(ok, 32'hFFFF_FF85, 1'b0);
        finish_resp();
    endtask

    task automatic test_params_timeout();
        bit ok;
        int ph_fail = 0;
        cfg_write(4'd10, 32'd0, 1'b1);
        push_params_and_start();
        push_polls_read(16, 1'b0);
        done_at = 0;
        pulse_go();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (cfu_en !== 1'b1 || cfu_cmd !== exp_seq[k]) begin
                errors++;
                $display("FAIL params_cycle%0d: got en=%b cmd=%0d, required en=1 cmd=%0d", k, cfu_en, cfu_cmd, exp_seq[k]);
            end
        end
        wait_res(ok);
        check_result(ok, 32'd0, 1'b1);
        checks++;
        if (polls != 16) begin
            errors++;
            $display("FAIL poll_count: got %0d polls, required 16", polls);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== 32'd0 || res_timeout !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL resp_hold: got valid=%b data=%h timeout=%b busy=%b, required 1 0 1 1", res_valid, res_data, res_timeout, busy);
            end
        end
        finish_resp();
    endtask

    task automatic test_flt_stall();
        bit ok;
        for (int a = 12; a < 16; a++) cfg_write(4'(a), 32'hDEAD_0000 + 32'(a), 1'b0);
        cfg_write(4'd11, 32'd4, 1'b1);
        n_cmd2 = 0;
        byte_q.delete();
        for (int k = 0; k < 4; k++) begin
            byte_q.push_back(8'hA0 + 8'(k));
            push_op(7'd2, 32'(k), 32'h0000_00A0 + 32'(k));
        end
        push_params_and_start();
        push_polls_read(2, 1'b1);
        done_at = 1;
        read_val = 32'h1234_5678;
        pulse_go();
        cfg_write(4'd3, 32'h0000_5555, 1'b0);
        pulse_go();
        drive_bytes(1'b1);
        wait_res(ok);
        check_result(ok, 32'h1234_5678, 1'b0);
        checks++;
        if (n_cmd2 != 4) begin
            errors++;
            $display("FAIL flt_writes: got %0d cmd-2 writes, required 4", n_cmd2);
        end
        finish_resp();
    endtask

    task automatic test_reset_mid_params();
        bit ok;
        cfg_write(4'd11, 32'd0, 1'b1);
        push_op(7'd3, 32'd0, m_cfg[0]);
        pulse_go();
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cfu_en !== 1'b0 || cfu_cmd !== 7'd0 || cfu_inp1 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b en=%b cmd=%0d inp1=%h, required 0", busy, cfu_en, cfu_cmd, cfu_inp1);
        end
        checks++;
        if (res_data !== 32'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_state: got res_data=%h pending=%0d, required 0 0", res_data, sb.size());
        end
        sb.delete();
        for (int k = 0; k < 12; k++) m_cfg[k] = 32'd0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        cfg_write(4'd10, 32'd2, 1'b1);
        byte_q.delete();
        byte_q.push_back(8'h11);
        byte_q.push_back(8'h22);
        push_op(7'd1, 32'd0, 32'h11);
        push_op(7'd1, 32'd1, 32'h22);
        push_params_and_start();
        push_polls_read(2, 1'b1);
        done_at = 1;
        read_val = 32'h0BAD_F00D;
        pulse_go();
        drive_bytes(1'b0);
        wait_res(ok);
        check_result(ok, 32'h0BAD_F00D, 1'b0);
        finish_resp();
    endtask

    initial begin
        exp_seq = '{7'd3, 7'd5, 7'd8, 7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17, 7'd6};
        for (int k = 0; k < 12; k++) m_cfg[k] = 32'd0;
        test_reset();
        test_load_in_wrap();
        test_params_timeout();
        test_flt_stall();
        test_reset_mid_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
